// File: rtl/controller_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// controller_pkg : command type shared by the bus condition generator
// Rev 1.0
// ------------------------------------------------------------------
package controller_pkg;

   localparam int TIMER_W        = 20;
   localparam int HDR_EXIT_EDGES = 4;

   typedef enum logic [1:0] {
      CMD_START    = 2'd0,
      CMD_RSTART   = 2'd1,
      CMD_STOP     = 2'd2,
      CMD_HDR_EXIT = 2'd3
   } bus_cond_cmd_e;

   // Sequences ending in a STOP leave SCL released; the others keep it low.
   function automatic logic cmd_ends_high(input bus_cond_cmd_e cmd);
      return (cmd == CMD_STOP) || (cmd == CMD_HDR_EXIT);
   endfunction

endpackage
`default_nettype wire

// File: rtl/bus_cond_timer.sv
`default_nettype none
// ------------------------------------------------------------------
// bus_cond_timer : loadable saturating down-counter with expiry flag
// Rev 1.0
// ------------------------------------------------------------------
module bus_cond_timer
   import controller_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               load_i,
   input  logic [TIMER_W-1:0] load_val_i,
   output logic               expired_o
);

   logic [TIMER_W-1:0] count_d;
   logic [TIMER_W-1:0] count_q;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (count_q != '0) begin
         count_d = count_q - TIMER_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // A load of N reads as expired in the N-th cycle; 0 and 1 both give one cycle.
   assign expired_o = (count_q <= TIMER_W'(1));

endmodule
`default_nettype wire

// File: rtl/bus_condition_generator.sv
`default_nettype none
// ------------------------------------------------------------------
// bus_condition_generator : drives START/RSTART/STOP/HDR-exit patterns
// Rev 1.0
// ------------------------------------------------------------------
module bus_condition_generator
   import controller_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               enable_i,
   input  logic               cmd_valid_i,
   output logic               cmd_ready_o,
   input  logic [1:0]         cmd_i,
   input  logic               scl_i,
   input  logic               sda_i,
   output logic               scl_o,
   output logic               sda_o,
   input  logic [TIMER_W-1:0] t_r_i,
   input  logic [TIMER_W-1:0] t_hd_dat_i,
   input  logic [TIMER_W-1:0] t_su_sta_i,
   input  logic [TIMER_W-1:0] t_hd_sta_i,
   input  logic [TIMER_W-1:0] t_su_sto_i,
   input  logic [TIMER_W-1:0] t_buf_i,
   output logic               done_o,
   output logic               arb_lost_o,
   output logic               busy_o
);

   localparam int EXIT_CNT_W = $clog2(HDR_EXIT_EDGES);

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_SDA_REL = 4'd1,
      ST_SDA_LOW = 4'd2,
      ST_SCL_REL = 4'd3,
      ST_SU_STA  = 4'd4,
      ST_HD_STA  = 4'd5,
      ST_SU_STO  = 4'd6,
      ST_STO_REL = 4'd7,
      ST_BUF     = 4'd8,
      ST_EXIT_HI = 4'd9,
      ST_EXIT_LO = 4'd10,
      ST_DONE    = 4'd11
   } state_e;

   state_e                state_d,    state_q;
   bus_cond_cmd_e         cmd_d,      cmd_q;
   logic                  scl_d,      scl_q;
   logic                  sda_d,      sda_q;
   logic                  done_d,     done_q;
   logic                  arb_lost_d, arb_lost_q;
   logic                  scl_wait_d, scl_wait_q;
   logic [EXIT_CNT_W-1:0] exit_cnt_d, exit_cnt_q;

   logic                  tmr_load;
   logic [TIMER_W-1:0]    tmr_val;
   logic                  tmr_expired;

   bus_cond_timer u_timer (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .expired_o  (tmr_expired)
   );

   assign cmd_ready_o = enable_i && (state_q == ST_IDLE);
   assign busy_o      = (state_q != ST_IDLE);
   assign scl_o       = scl_q;
   assign sda_o       = sda_q;
   assign done_o      = done_q;
   assign arb_lost_o  = arb_lost_q;

   always_comb begin
      state_d    = state_q;
      cmd_d      = cmd_q;
      scl_d      = scl_q;
      sda_d      = sda_q;
      done_d     = 1'b0;
      arb_lost_d = 1'b0;
      scl_wait_d = scl_wait_q;
      exit_cnt_d = exit_cnt_q;
      tmr_load   = 1'b0;
      tmr_val    = '0;

      if ((state_q != ST_IDLE) && !enable_i) begin
         state_d = ST_IDLE;
         scl_d   = 1'b1;
         sda_d   = 1'b1;
      end else if (((state_q == ST_SU_STA) || (state_q == ST_BUF)) && !sda_i) begin
         // SDA is released here, so a low level means another master owns the bus
         state_d    = ST_IDLE;
         scl_d      = 1'b1;
         sda_d      = 1'b1;
         arb_lost_d = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cmd_valid_i && cmd_ready_o) begin
                  cmd_d      = bus_cond_cmd_e'(cmd_i);
                  exit_cnt_d = '0;
                  case (bus_cond_cmd_e'(cmd_i))
                     CMD_START:  state_d = ST_SU_STA;
                     CMD_RSTART: state_d = ST_SDA_REL;
                     CMD_STOP:   state_d = ST_SDA_LOW;
                     default:    state_d = ST_EXIT_HI;
                  endcase
               end
            end
            ST_SDA_REL, ST_SDA_LOW: begin
               if (tmr_expired) state_d = ST_SCL_REL;
            end
            ST_SCL_REL: begin
               // Wait out any clock stretching before timing the rise
               if (scl_wait_q) begin
                  if (scl_i) begin
                     scl_wait_d = 1'b0;
                     tmr_load   = 1'b1;
                     tmr_val    = t_r_i;
                  end
               end else if (tmr_expired) begin
                  state_d = cmd_ends_high(cmd_q) ? ST_SU_STO : ST_SU_STA;
               end
            end
            ST_SU_STA: begin
               if (tmr_expired) state_d = ST_HD_STA;
            end
            ST_HD_STA: begin
               if (tmr_expired) state_d = ST_DONE;
            end
            ST_SU_STO: begin
               if (tmr_expired) state_d = ST_STO_REL;
            end
            ST_STO_REL: begin
               if (tmr_expired) state_d = ST_BUF;
            end
            ST_BUF: begin
               if (tmr_expired) state_d = ST_DONE;
            end
            ST_EXIT_HI: begin
               if (tmr_expired) state_d = ST_EXIT_LO;
            end
            ST_EXIT_LO: begin
               if (tmr_expired) begin
                  if (exit_cnt_q == EXIT_CNT_W'(HDR_EXIT_EDGES - 1)) begin
                     state_d = ST_SCL_REL;
                  end else begin
                     exit_cnt_d = exit_cnt_q + EXIT_CNT_W'(1);
                     state_d    = ST_EXIT_HI;
                  end
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      // Drive levels and timer load belong to the state being entered
      if (state_d != state_q) begin
         tmr_load   = 1'b1;
         scl_wait_d = (state_d == ST_SCL_REL);
         case (state_d)
            ST_SDA_REL: begin scl_d = 1'b0; sda_d = 1'b1; tmr_val = t_r_i;      end
            ST_SDA_LOW: begin scl_d = 1'b0; sda_d = 1'b0; tmr_val = t_hd_dat_i; end
            ST_SCL_REL: begin scl_d = 1'b1;                                     end
            ST_SU_STA:  begin scl_d = 1'b1; sda_d = 1'b1; tmr_val = t_su_sta_i; end
            ST_HD_STA:  begin scl_d = 1'b1; sda_d = 1'b0; tmr_val = t_hd_sta_i; end
            ST_SU_STO:  begin scl_d = 1'b1; sda_d = 1'b0; tmr_val = t_su_sto_i; end
            ST_STO_REL: begin scl_d = 1'b1; sda_d = 1'b1;                       end
            ST_BUF:     begin scl_d = 1'b1; sda_d = 1'b1; tmr_val = t_buf_i;    end
            ST_EXIT_HI: begin scl_d = 1'b0; sda_d = 1'b1; tmr_val = t_hd_dat_i; end
            ST_EXIT_LO: begin scl_d = 1'b0; sda_d = 1'b0; tmr_val = t_hd_dat_i; end
            ST_DONE:    begin scl_d = cmd_ends_high(cmd_q); done_d = 1'b1;      end
            default:    begin                                                   end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         cmd_q      <= CMD_START;
         scl_q      <= 1'b1;
         sda_q      <= 1'b1;
         done_q     <= 1'b0;
         arb_lost_q <= 1'b0;
         scl_wait_q <= 1'b0;
         exit_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         cmd_q      <= cmd_d;
         scl_q      <= scl_d;
         sda_q      <= sda_d;
         done_q     <= done_d;
         arb_lost_q <= arb_lost_d;
         scl_wait_q <= scl_wait_d;
         exit_cnt_q <= exit_cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bus_condition_generator.sv
`default_nettype none
`timescale 1ns/1ps
// ------------------------------------------------------------------
// tb_bus_condition_generator : directed and random checks against a cycle-list model
// Rev 1.0
// ------------------------------------------------------------------
module tb_bus_condition_generator;

   localparam int PH_OTHER   = 0;
   localparam int PH_SU_STA  = 1;
   localparam int PH_HD_STA  = 2;
   localparam int PH_BUF     = 3;
   localparam int PH_EXIT_LO = 4;
   localparam int PH_DONE    = 5;
   localparam int PH_IDLE    = 6;

   localparam int INJ_NONE = 0;
   localparam int INJ_ARB  = 1;
   localparam int INJ_EN   = 2;
   localparam int INJ_RST  = 3;

   logic        clk = 1'b0;
   logic        rst, enable, cmd_valid, cmd_ready;
   logic [1:0]  cmd;
   logic        scl_hold, sda_force;
   logic        scl_bus, sda_bus;
   logic        scl_o, sda_o, done, arb_lost, busy;
   logic [19:0] t_r, t_hd_dat, t_su_sta, t_hd_sta, t_su_sto, t_buf;

   // Open-drain loopback; the bench can stretch SCL or pull SDA low
   assign scl_bus = scl_o & ~scl_hold;
   assign sda_bus = sda_o & ~sda_force;

   always #5 clk = ~clk;

   bus_condition_generator dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .enable_i    (enable),
      .cmd_valid_i (cmd_valid),
      .cmd_ready_o (cmd_ready),
      .cmd_i       (cmd),
      .scl_i       (scl_bus),
      .sda_i       (sda_bus),
      .scl_o       (scl_o),
      .sda_o       (sda_o),
      .t_r_i       (t_r),
      .t_hd_dat_i  (t_hd_dat),
      .t_su_sta_i  (t_su_sta),
      .t_hd_sta_i  (t_hd_sta),
      .t_su_sto_i  (t_su_sto),
      .t_buf_i     (t_buf),
      .done_o      (done),
      .arb_lost_o  (arb_lost),
      .busy_o      (busy)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One entry per clock cycle after the accepting edge
   typedef struct {
      bit scl; bit sda; bit done; bit arb; bit busy;
      bit hold; bit force_lo; bit drop_en; bit rst;
      int ph;
   } cyc_t;

   cyc_t exp_q[$];
   bit   prev_scl = 1'b1, prev_sda = 1'b1;
   int   n_start = 0, n_stop = 0, n_low_fall = 0;

   function automatic void push(bit scl, bit sda, int ph, bit hold, bit dn, bit bsy, bit arb);
      cyc_t c;
      c.scl = scl; c.sda = sda; c.done = dn; c.arb = arb; c.busy = bsy;
      c.hold = hold; c.force_lo = 1'b0; c.drop_en = 1'b0; c.rst = 1'b0; c.ph = ph;
      exp_q.push_back(c);
   endfunction

   function automatic void seg(bit scl, bit sda, int n, int ph);
      for (int i = 0; i < ((n < 1) ? 1 : n); i++) push(scl, sda, ph, 1'b0, 1'b0, 1'b1, 1'b0);
   endfunction

   // SCL released: stretched for s cycles, one cycle to see it high, then t_r
   function automatic void scl_release(int s);
      bit hold_sda;
      hold_sda = exp_q[$].sda;
      for (int i = 0; i < s; i++) push(1'b1, hold_sda, PH_OTHER, 1'b1, 1'b0, 1'b1, 1'b0);
      push(1'b1, hold_sda, PH_OTHER, 1'b0, 1'b0, 1'b1, 1'b0);
      seg(1'b1, hold_sda, int'(t_r), PH_OTHER);
   endfunction

   function automatic void stop_tail();
      seg(1'b1, 1'b0, int'(t_su_sto), PH_OTHER);
      seg(1'b1, 1'b1, 1, PH_OTHER);
      seg(1'b1, 1'b1, int'(t_buf), PH_BUF);
   endfunction

   function automatic void build(int c, int s);
      bit lvl_scl, lvl_sda;
      exp_q.delete();
      case (c)
         0: begin
            seg(1'b1, 1'b1, int'(t_su_sta), PH_SU_STA);
            seg(1'b1, 1'b0, int'(t_hd_sta), PH_HD_STA);
         end
         1: begin
            seg(1'b0, 1'b1, int'(t_r), PH_OTHER);
            scl_release(s);
            seg(1'b1, 1'b1, int'(t_su_sta), PH_SU_STA);
            seg(1'b1, 1'b0, int'(t_hd_sta), PH_HD_STA);
         end
         2: begin
            seg(1'b0, 1'b0, int'(t_hd_dat), PH_OTHER);
            scl_release(s);
            stop_tail();
         end
         default: begin
            for (int e = 0; e < 4; e++) begin
               seg(1'b0, 1'b1, int'(t_hd_dat), PH_OTHER);
               seg(1'b0, 1'b0, int'(t_hd_dat), PH_EXIT_LO);
            end
            scl_release(s);
            stop_tail();
         end
      endcase
      push((c >= 2), exp_q[$].sda, PH_DONE, 1'b0, 1'b1, 1'b1, 1'b0);
      lvl_scl = exp_q[$].scl;
      lvl_sda = exp_q[$].sda;
      push(lvl_scl, lvl_sda, PH_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
   endfunction

   function automatic void inject(int kind, int want_ph);
      int   cand[$];
      int   idx;
      cyc_t c;
      if (kind == INJ_NONE) return;
      for (int i = 0; i < exp_q.size(); i++) begin
         if (exp_q[i].busy && exp_q[i].ph != PH_DONE &&
             (want_ph < 0 || exp_q[i].ph == want_ph) &&
             (kind != INJ_ARB || exp_q[i].ph == PH_SU_STA || exp_q[i].ph == PH_BUF))
            cand.push_back(i);
      end
      if (cand.size() == 0) return;
      idx = cand[$urandom_range(0, cand.size() - 1)];
      while (exp_q.size() > idx + 1) void'(exp_q.pop_back());
      c = exp_q[idx];
      c.force_lo = (kind == INJ_ARB);
      c.drop_en  = (kind == INJ_EN);
      c.rst      = (kind == INJ_RST);
      exp_q[idx] = c;
      push(1'b1, 1'b1, PH_IDLE, 1'b0, 1'b0, 1'b0, (kind == INJ_ARB));
   endfunction

   task automatic set_t(input int r, input int hd, input int susta, input int hdsta,
                        input int susto, input int bf);
      t_r = 20'(r); t_hd_dat = 20'(hd); t_su_sta = 20'(susta);
      t_hd_sta = 20'(hdsta); t_su_sto = 20'(susto); t_buf = 20'(bf);
   endtask

   task automatic run(input int c, input int s, input int kind, input int want_ph);
      build(c, s);
      inject(kind, want_ph);
      cmd_valid = 1'b1;
      cmd       = 2'(c);
      @(posedge clk); #1;
      for (int k = 0; k < exp_q.size(); k++) begin
         cmd_valid = exp_q[k].busy ? 1'($urandom_range(0, 1)) : 1'b0;
         cmd       = 2'($urandom_range(0, 3));
         scl_hold  = exp_q[k].hold;
         sda_force = exp_q[k].force_lo;
         enable    = !exp_q[k].drop_en;
         rst       = exp_q[k].rst;
         @(negedge clk);
         check($sformatf("c%0d_cyc%0d", c, k), {27'd0, scl_o, sda_o, done, arb_lost, busy},
               {27'd0, exp_q[k].scl, exp_q[k].sda, exp_q[k].done, exp_q[k].arb, exp_q[k].busy});
         if (prev_scl && scl_o && prev_sda && !sda_o)   n_start++;
         if (prev_scl && scl_o && !prev_sda && sda_o)   n_stop++;
         if (!prev_scl && !scl_o && prev_sda && !sda_o) n_low_fall++;
         prev_scl = scl_o;
         prev_sda = sda_o;
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      scl_hold  = 1'b0;
      sda_force = 1'b0;
      enable    = 1'b1;
      rst       = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int a, b;
      rst = 1'b1; enable = 1'b1; cmd_valid = 1'b0; cmd = 2'd0;
      scl_hold = 1'b0; sda_force = 1'b0;
      set_t(0, 0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_out", {27'd0, scl_o, sda_o, done, arb_lost, busy}, 32'b11000);
      check("reset_ready", {31'd0, cmd_ready}, 32'd1);
      @(posedge clk); #1;

      // Disabled: commands are refused
      enable = 1'b0; cmd_valid = 1'b1; cmd = 2'd0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("dis_ready", {31'd0, cmd_ready}, 32'd0);
         check("dis_busy", {31'd0, busy}, 32'd0);
         @(posedge clk); #1;
      end
      enable = 1'b1; cmd_valid = 1'b0;
      @(negedge clk);
      check("en_ready", {31'd0, cmd_ready}, 32'd1);
      @(posedge clk); #1;

      set_t(2, 3, 5, 4, 3, 2);
      run(0, 0, INJ_NONE, -1);
      set_t(2, 1, 2, 2, 3, 4);
      run(2, 20, INJ_NONE, -1);
      set_t(2, 3, 2, 2, 2, 2);
      a = n_low_fall;
      run(3, 1, INJ_NONE, -1);
      check("hdr_low_falls", 32'(n_low_fall - a), 32'd4);
      run(1, 2, INJ_ARB, PH_SU_STA);
      run(0, 0, INJ_EN, PH_HD_STA);
      run(3, 0, INJ_RST, PH_EXIT_LO);

      set_t(0, 0, 0, 0, 0, 0);
      a = n_start; b = n_stop;
      run(0, 0, INJ_NONE, -1);
      check("zero_start", 32'(n_start - a), 32'd1);
      run(1, 0, INJ_NONE, -1);
      check("zero_rstart", 32'(n_start - a), 32'd2);
      check("zero_no_stop", 32'(n_stop - b), 32'd0);
      run(2, 0, INJ_NONE, -1);
      check("zero_stop", 32'(n_stop - b), 32'd1);

      for (int it = 0; it < 150; it++) begin
         int sel;
         set_t($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
               $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4));
         sel = $urandom_range(0, 7);
         run($urandom_range(0, 3), $urandom_range(0, 3), (sel < 5) ? INJ_NONE : sel - 4, -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/bus_condition_generator.md
BUS_CONDITION_GENERATOR -- requirements
Module: bus_condition_generator

Interface
REQ-001 SHALL have clk_i, input, 1, single clock; all logic on posedge.
REQ-002 SHALL have rst_i, input, 1, synchronous active-high reset.
REQ-003 SHALL have enable_i, input, 1; low aborts any sequence and holds IDLE.
REQ-004 SHALL have cmd_valid_i input 1, cmd_ready_o output 1, cmd_i input 2 (bus_cond_cmd_e: START=0, RSTART=1, STOP=2, HDR_EXIT=3).
REQ-005 SHALL have scl_i, sda_i, inputs, 1 each, synchronized bus levels.
REQ-006 SHALL have scl_o, sda_o, outputs, 1 each, open-drain drive values (1 = release, 0 = pull low).
REQ-007 SHALL have t_r_i, t_hd_dat_i, t_su_sta_i, t_hd_sta_i, t_su_sto_i, t_buf_i, inputs, 20 each, durations in clk_i cycles.
REQ-008 SHALL have done_o output 1 (sequence-complete pulse), arb_lost_o output 1 (abort pulse), busy_o output 1.

Function
REQ-009 Handshake: command accepted when cmd_valid_i & cmd_ready_o; cmd_ready_o = enable_i & (state==IDLE); first sequence state entered the next cycle.
REQ-010 Timed states: a 20-bit down-counter loads on state entry; state lasts max(N,1) cycles, N = the state's timing input, sampled at entry.
REQ-011 States: IDLE, SDA_REL, SDA_LOW, SCL_REL, SU_STA, HD_STA, SU_STO, STO_REL, BUF, EXIT_HI, EXIT_LO, DONE.
REQ-012 Drive per state (scl_o/sda_o): SDA_REL 0/1, SDA_LOW 0/0, SCL_REL 1/hold, SU_STA 1/1, HD_STA 1/0, SU_STO 1/0, STO_REL 1/1, BUF 1/1, EXIT_HI 0/1, EXIT_LO 0/0.
REQ-013 START: SU_STA(t_su_sta) -> HD_STA(t_hd_sta) -> DONE.
REQ-014 RSTART: SDA_REL(t_r) -> SCL_REL -> SU_STA -> HD_STA -> DONE.
REQ-015 STOP: SDA_LOW(t_hd_dat) -> SCL_REL -> SU_STO(t_su_sto) -> STO_REL(1 cycle) -> BUF(t_buf) -> DONE.
REQ-016 HDR_EXIT: (EXIT_HI(t_hd_dat) -> EXIT_LO(t_hd_dat)) x4, giving exactly 4 SDA falling edges with SCL low, then SCL_REL and continue as STOP from SU_STO.
REQ-017 SCL_REL is untimed: waits until scl_i==1 (clock stretching, unbounded), then t_r cycles, then next state.
REQ-018 DONE: scl_o=0 after START/RSTART, scl_o=1 after STOP/HDR_EXIT; done_o=1 for exactly that one cycle; then IDLE.
REQ-019 IDLE holds the last driven scl_o/sda_o levels; busy_o = (state != IDLE).
REQ-020 Arbitration: sda_i==0 sampled during SU_STA or BUF -> arb_lost_o pulse one cycle, scl_o=sda_o=1, IDLE next cycle, no done_o.
REQ-021 enable_i low in any non-IDLE state -> IDLE next cycle, scl_o=sda_o=1, no done_o, no arb_lost_o.
REQ-022 cmd_valid_i while busy_o is ignored (not queued); done_o and arb_lost_o never asserted together.
REQ-023 Counter SHALL saturate at 0; no wrap-around.

Reset
REQ-024 On rst_i: state=IDLE, scl_o=1, sda_o=1, done_o=0, arb_lost_o=0, busy_o=0, counter=0, exit-edge count=0; cmd_ready_o follows enable_i next cycle.
REQ-025 rst_i mid-sequence SHALL take effect on that clock edge regardless of enable_i or bus state.

Structure
REQ-026 bus_cond_cmd_e SHALL reside in controller_pkg; state enum local to module.
REQ-027 Single sub-module bus_cond_timer (20-bit loadable saturating down-counter, expired flag) SHALL implement REQ-010.

Verification
REQ-028 Idle bus, START, t_su_sta=5, t_hd_sta=4 -> SDA falls 5 cycles after accept, SCL falls 4 cycles later, done_o one pulse.
REQ-029 SCL low, STOP, scl_i held low 20 cycles by bench -> sequence waits in SCL_REL, then t_su_sto, SDA rises with SCL high, done_o after t_buf.
REQ-030 HDR_EXIT, t_hd_dat=3 -> exactly 4 SDA negedges with scl_o=0, then STOP; bus_monitor reports hdr_exit_detect_o.
REQ-031 RSTART with bench forcing sda_i=0 during SU_STA -> arb_lost_o one pulse, both lines released, no done_o.
REQ-032 enable_i dropped mid-HD_STA; separately rst_i mid-EXIT_LO -> IDLE next cycle, lines released, no pulses.
REQ-033 All timings=0 -> each timed state lasts 1 cycle; loopback to bus_monitor detects START, RSTART, STOP in order.
